dma_timing_control: RTL and testbench

Timing and control sequencer for the 4-channel DMA controller. It sits directly upstream of the DMA datapath.
- Arbitrates channel requests and handles the HRQ/HLDA bus handshake.
- Generates the per-transfer control pulses the datapath consumes: ld_temp_addr, ld_upper_address, ld_lower_address, addr_gen.
- Drives the system bus strobes and DACK.

---
 rtl/dma_pkg.sv | 25 ++
 rtl/dma_timing_control_arbiter.sv | 43 ++++
 rtl/dma_timing_control.sv | 168 ++++++++++++++++
 tb/tb_dma_timing_control.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA timing/control sequencer.
package dma_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef logic [CH_W-1:0] chIdx_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    S4   = 3'd5
  } dmaState_t;

  typedef enum logic [1:0] {
    MODE_DEMAND  = 2'b00,
    MODE_SINGLE  = 2'b01,
    MODE_BLOCK   = 2'b10,
    MODE_CASCADE = 2'b11
  } dmaMode_t;

endpackage

// File: rtl/dma_timing_control_arbiter.sv
// Fixed/rotating channel arbiter; owns the rotation pointer (last serviced channel).
module dma_priority_arbiter
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] eff,
  input  logic              rotatingPriority,
  input  logic              update,
  input  chIdx_t            servicedCh,
  output logic              grantValid,
  output chIdx_t            grant
);

  chIdx_t lastCh;

  // Reset value makes ch0 the highest-priority channel under rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastCh <= chIdx_t'(NUM_CH - 1);
    end else if (update) begin
      lastCh <= servicedCh;
    end
  end

  // Scan from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    chIdx_t startCh;
    chIdx_t idx;
    grantValid = 1'b0;
    grant      = '0;
    startCh    = rotatingPriority ? chIdx_t'(lastCh + chIdx_t'(1)) : '0;
    idx        = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      idx = chIdx_t'(startCh + chIdx_t'(i));
      if (eff[idx]) begin
        grantValid = 1'b1;
        grant      = idx;
      end
    end
  end

endmodule

// File: rtl/dma_timing_control.sv
// DMA timing and control sequencer: arbitration, HRQ/HLDA handshake, bus strobes and datapath pulses.
module dma_timing_control
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              hlda,
  input  logic [NUM_CH-1:0] dreq,
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] req_reg,
  input  logic              rotating_priority,
  input  logic [7:0]        chan_mode,
  input  logic              is_read,
  input  logic              tc,
  input  logic              eop_n,
  output logic              hrq,
  output logic [NUM_CH-1:0] dack,
  output logic [1:0]        sel,
  output logic              aen,
  output logic              adstb,
  output logic              ld_temp_addr,
  output logic              ld_upper_address,
  output logic              ld_lower_address,
  output logic              addr_gen,
  output logic              memr_n,
  output logic              memw_n,
  output logic              ior_n,
  output logic              iow_n,
  output logic              eop_out,
  output logic [NUM_CH-1:0] clr_sw_req
);

  dmaState_t         state;
  logic              holdLost;
  logic [NUM_CH-1:0] eff;
  logic [NUM_CH-1:0] selOneHot;
  dmaMode_t          selMode;
  logic              grantValid;
  chIdx_t            grant;
  logic              s4Done;
  logic              s4Continue;

  assign eff       = (dreq & ~mask) | req_reg;
  assign selOneHot = NUM_CH'(1) << sel;
  assign selMode   = dmaMode_t'(chan_mode[{sel, 1'b0} +: 2]);
  assign s4Done    = tc | ~eop_n;
  assign s4Continue = ~s4Done & ~holdLost & hlda &
                      ((selMode == MODE_BLOCK) | ((selMode == MODE_DEMAND) & dreq[sel]));

  dma_priority_arbiter uArbiter (
    .clk              (clk),
    .rst              (rst),
    .eff              (eff),
    .rotatingPriority (rotating_priority),
    .update           (state == S4),
    .servicedCh       (sel),
    .grantValid       (grantValid),
    .grant            (grant)
  );

  // Outputs are registered for the state being entered, so they line up with that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      holdLost         <= 1'b0;
      sel              <= '0;
      hrq              <= 1'b0;
      aen              <= 1'b0;
      dack             <= '0;
      adstb            <= 1'b0;
      ld_temp_addr     <= 1'b0;
      ld_upper_address <= 1'b0;
      ld_lower_address <= 1'b0;
      addr_gen         <= 1'b0;
      memr_n           <= 1'b1;
      memw_n           <= 1'b1;
      ior_n            <= 1'b1;
      iow_n            <= 1'b1;
      eop_out          <= 1'b0;
      clr_sw_req       <= '0;
    end else begin
      hrq              <= 1'b0;
      aen              <= 1'b0;
      dack             <= '0;
      adstb            <= 1'b0;
      ld_temp_addr     <= 1'b0;
      ld_upper_address <= 1'b0;
      ld_lower_address <= 1'b0;
      addr_gen         <= 1'b0;
      memr_n           <= 1'b1;
      memw_n           <= 1'b1;
      ior_n            <= 1'b1;
      iow_n            <= 1'b1;
      eop_out          <= 1'b0;
      clr_sw_req       <= '0;

      case (state)
        IDLE: begin
          if (cs_n && grantValid) begin
            sel   <= grant;
            hrq   <= 1'b1;
            state <= S0;
          end
        end

        S0: begin
          if (hlda) begin
            hrq              <= 1'b1;
            aen              <= 1'b1;
            adstb            <= 1'b1;
            ld_upper_address <= 1'b1;
            ld_temp_addr     <= 1'b1;
            holdLost         <= 1'b0;
            state            <= S1;
          end else if (!eff[sel]) begin
            state <= IDLE;
          end else begin
            hrq <= 1'b1;
          end
        end

        S1, S2: begin
          hrq              <= 1'b1;
          aen              <= 1'b1;
          dack             <= selOneHot;
          ld_lower_address <= 1'b1;
          if (is_read) memr_n <= 1'b0;
          else         ior_n  <= 1'b0;
          if (state == S2) begin
            if (is_read) iow_n  <= 1'b0;
            else         memw_n <= 1'b0;
          end
          if (!hlda) holdLost <= 1'b1;
          state <= (state == S1) ? S2 : S3;
        end

        S3: begin
          hrq      <= 1'b1;
          aen      <= 1'b1;
          dack     <= selOneHot;
          addr_gen <= 1'b1;
          if (!hlda) holdLost <= 1'b1;
          state <= S4;
        end

        S4: begin
          if (s4Done) begin
            eop_out    <= 1'b1;
            clr_sw_req <= selOneHot;
          end
          if (s4Continue) begin
            hrq              <= 1'b1;
            aen              <= 1'b1;
            adstb            <= 1'b1;
            ld_upper_address <= 1'b1;
            state            <= S1;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_timing_control.sv
// Directed self-checking bench for dma_timing_control.
module tb_dma_timing_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       hlda = 1'b0;
  logic [3:0] dreq = '0;
  logic [3:0] mask = '0;
  logic [3:0] req_reg = '0;
  logic       rotating_priority = 1'b0;
  logic [7:0] chan_mode = 8'h55;
  logic       is_read = 1'b1;
  logic       tc = 1'b0;
  logic       eop_n = 1'b1;

  logic       hrq, aen, adstb, ld_temp_addr, ld_upper_address, ld_lower_address, addr_gen;
  logic       memr_n, memw_n, ior_n, iow_n, eop_out;
  logic [3:0] dack, clr_sw_req;
  logic [1:0] sel;

  int nErr = 0;
  int nChecks = 0;
  int agCnt, ltCnt, eopSeen;

  dma_timing_control dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .hlda(hlda), .dreq(dreq), .mask(mask),
    .req_reg(req_reg), .rotating_priority(rotating_priority), .chan_mode(chan_mode),
    .is_read(is_read), .tc(tc), .eop_n(eop_n), .hrq(hrq), .dack(dack), .sel(sel),
    .aen(aen), .adstb(adstb), .ld_temp_addr(ld_temp_addr),
    .ld_upper_address(ld_upper_address), .ld_lower_address(ld_lower_address),
    .addr_gen(addr_gen), .memr_n(memr_n), .memw_n(memw_n), .ior_n(ior_n), .iow_n(iow_n),
    .eop_out(eop_out), .clr_sw_req(clr_sw_req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {memr_n, memw_n, ior_n, iow_n};
  endfunction

  // One single-mode transfer starting from IDLE; CPU grants hold right away.
  task automatic xfer(input logic [1:0] expSel);
    tick();
    chk("xfer_s0_hrq", 8'(hrq), 8'd1);
    chk("xfer_sel", 8'(sel), 8'(expSel));
    hlda = 1'b1;
    tick();
    tick();
    chk("xfer_dack", 8'(dack), 8'(4'b0001 << expSel));
    tick();
    tick();
    chk("xfer_addr_gen", 8'(addr_gen), 8'd1);
    hlda = 1'b0;
    tick();
    chk("xfer_idle_hrq", 8'(hrq), 8'd0);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_hrq", 8'(hrq), 8'd0);
    chk("rst_dack", 8'(dack), 8'd0);
    chk("rst_sel", 8'(sel), 8'd0);
    chk("rst_strobes", 8'(strobes()), 8'hF);
    chk("rst_pulses", 8'({aen, adstb, ld_temp_addr, ld_upper_address, ld_lower_address,
                          addr_gen, eop_out}), 8'd0);
    chk("rst_clr", 8'(clr_sw_req), 8'd0);
    rst = 1'b0;

    // Fixed priority, single mode, memory-to-IO
    dreq = 4'b0101;
    tick();
    chk("fx_hrq", 8'(hrq), 8'd1);
    chk("fx_sel", 8'(sel), 8'd0);
    tick();
    chk("fx_wait_hrq", 8'(hrq), 8'd1);
    chk("fx_wait_ldt", 8'(ld_temp_addr), 8'd0);
    hlda = 1'b1;
    tick();
    chk("fx_s1", 8'({ld_temp_addr, adstb, aen, ld_upper_address}), 8'hF);
    tick();
    chk("fx_s2_strobes", 8'(strobes()), 8'b0111);
    chk("fx_s2_dack", 8'(dack), 8'b0001);
    chk("fx_s2_ldl_ldt", 8'({ld_lower_address, ld_temp_addr}), 8'b10);
    tick();
    chk("fx_s3_strobes", 8'(strobes()), 8'b0110);
    tick();
    chk("fx_s4_strobes", 8'(strobes()), 8'hF);
    chk("fx_s4_ag_dack", 8'({addr_gen, dack}), 8'h11);
    tick();
    chk("fx_idle", 8'({hrq, aen, dack, eop_out}), 8'd0);
    hlda = 1'b0;
    tick();
    chk("fx_rearb_hrq", 8'(hrq), 8'd1);
    chk("fx_rearb_sel", 8'(sel), 8'd0);
    dreq = 4'b0000;
    tick();
    chk("fx_drop_hrq", 8'(hrq), 8'd0);
    tick();
    chk("fx_drop_stay", 8'(hrq), 8'd0);

    // Rotating priority, all channels requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rotating_priority = 1'b1;
    dreq = 4'b1111;
    xfer(2'd0);
    xfer(2'd1);
    xfer(2'd2);
    xfer(2'd3);
    xfer(2'd0);
    dreq = 4'b0000;
    rotating_priority = 1'b0;
    tick();
    chk("rot_end_idle", 8'(hrq), 8'd0);

    // Block mode on ch2 started from the software request, TC on the third S4
    chan_mode = 8'h65;
    req_reg = 4'b0100;
    tick();
    chk("blk_sel", 8'(sel), 8'd2);
    hlda = 1'b1;
    agCnt = 0;
    ltCnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (addr_gen) agCnt++;
      if (ld_temp_addr) ltCnt++;
      if (agCnt == 3) tc = 1'b1;
    end
    tick();
    chk("blk_eop", 8'(eop_out), 8'd1);
    chk("blk_clr", 8'(clr_sw_req), 8'b0100);
    chk("blk_idle", 8'({hrq, dack}), 8'd0);
    chk("blk_ag_cnt", 8'(agCnt), 8'd3);
    chk("blk_ldt_cnt", 8'(ltCnt), 8'd1);
    tc = 1'b0;
    req_reg = 4'b0000;
    hlda = 1'b0;
    tick();
    chk("blk_eop_pulse", 8'({eop_out, clr_sw_req}), 8'd0);

    // Demand mode on ch1, dreq drops during the second transfer
    chan_mode = 8'h51;
    dreq = 4'b0010;
    tick();
    chk("dem_sel", 8'(sel), 8'd1);
    hlda = 1'b1;
    agCnt = 0;
    eopSeen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (addr_gen) agCnt++;
      if (eop_out) eopSeen++;
      if (i == 5) dreq = 4'b0000;
    end
    tick();
    if (eop_out) eopSeen++;
    chk("dem_idle", 8'(hrq), 8'd0);
    chk("dem_ag_cnt", 8'(agCnt), 8'd2);
    chk("dem_no_eop", 8'(eopSeen), 8'd0);
    hlda = 1'b0;

    // Masked hardware request and host chip-select
    mask = 4'b0001;
    dreq = 4'b0001;
    tick();
    tick();
    tick();
    chk("mask_hrq", 8'(hrq), 8'd0);
    mask = 4'b0000;
    dreq = 4'b0010;
    cs_n = 1'b0;
    tick();
    tick();
    chk("cs_hrq", 8'(hrq), 8'd0);
    cs_n = 1'b1;
    tick();
    chk("cs_rel_hrq", 8'(hrq), 8'd1);
    chk("cs_rel_sel", 8'(sel), 8'd1);
    dreq = 4'b0000;
    tick();
    chk("cs_drop_hrq", 8'(hrq), 8'd0);

    // Reset in S3, then ch0 must win under rotation
    chan_mode = 8'h55;
    rotating_priority = 1'b1;
    dreq = 4'b0001;
    tick();
    chk("mid_sel", 8'(sel), 8'd0);
    hlda = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_s3_strobes", 8'(strobes()), 8'b0110);
    rst = 1'b1;
    tick();
    chk("mid_rst_strobes", 8'(strobes()), 8'hF);
    chk("mid_rst_dack_hrq", 8'({hrq, dack}), 8'd0);
    rst = 1'b0;
    hlda = 1'b0;
    dreq = 4'b1111;
    tick();
    chk("mid_post_hrq", 8'(hrq), 8'd1);
    chk("mid_post_sel", 8'(sel), 8'd0);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
